// File: rtl/async_event_reporter.sv
// Synchronizes and debounces one board input, counts debounced edges and offers each new
// count to uart_tx as a byte. Define ASYNC_EVENT_LEVEL_MSB_EN to carry the level in tx_data[7].
`timescale 1ns/1ps
module async_event_reporter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int CNT_W           = 19
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       async_in,
   output logic       level,
   output logic       event_pulse,
   output logic [7:0] tx_data,
   output logic       tx_data_valid,
   input  logic       tx_data_ready,
   output logic       busy,
   output logic       overrun
);
   typedef enum logic {IDLE, SEND} state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s_in;
   logic [CNT_W-1:0]       db_cnt_reg;
   logic                   level_reg;
   logic                   event_pulse_reg;
   logic [7:0]             event_cnt_reg;
   logic [7:0]             newest_cnt;
   logic [7:0]             offer_byte;
   state_t                 state_reg, state_next;
   logic                   pending_reg, pending_next;
   logic [7:0]             tx_data_reg, tx_data_next;
   logic                   overrun_reg, overrun_next;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      end
   end

   assign s_in = sync_reg[SYNC_STAGES-1];

   // The level only moves after s_in has disagreed with it for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         db_cnt_reg      <= '0;
         level_reg       <= 1'b0;
         event_pulse_reg <= 1'b0;
      end else begin
         event_pulse_reg <= 1'b0;
         if (s_in == level_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg       <= s_in;
            event_pulse_reg <= 1'b1;
            db_cnt_reg      <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         event_cnt_reg <= 8'd0;
      end else if (event_pulse_reg) begin
         event_cnt_reg <= event_cnt_reg + 8'd1;
      end
   end

   // Count as it will be after this edge, so a byte captured alongside an event is current.
   assign newest_cnt = event_pulse_reg ? (event_cnt_reg + 8'd1) : event_cnt_reg;

`ifdef ASYNC_EVENT_LEVEL_MSB_EN
   assign offer_byte = {level_reg, newest_cnt[6:0]};
`else
   assign offer_byte = newest_cnt;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg   <= IDLE;
         pending_reg <= 1'b0;
         tx_data_reg <= 8'h00;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         tx_data_reg <= tx_data_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      tx_data_next = tx_data_reg;
      overrun_next = overrun_reg;
      case (state_reg)
         IDLE: begin
            if (event_pulse_reg || pending_reg) begin
               tx_data_next = offer_byte;
               pending_next = 1'b0;
               state_next   = SEND;
            end
         end
         SEND: begin
            // Events during a send coalesce; a second one loses an intermediate count.
            if (event_pulse_reg) begin
               pending_next = 1'b1;
               if (pending_reg) begin
                  overrun_next = 1'b1;
               end
            end
            if (tx_data_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign level         = level_reg;
   assign event_pulse   = event_pulse_reg;
   assign tx_data       = tx_data_reg;
   assign tx_data_valid = (state_reg == SEND);
   assign busy          = (state_reg == SEND) | pending_reg;
   assign overrun       = overrun_reg;

endmodule

// File: tb/tb_async_event_reporter.sv
// Self-checking bench for async_event_reporter: directed scenarios plus randomized
// segment stimulus checked against a segment-level model of debounce and byte delivery.
`timescale 1ns/1ps
module tb_async_event_reporter;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int CNT_W           = 3;

   logic       sys_clk       = 1'b0;
   logic       sys_rst       = 1'b1;
   logic       async_in      = 1'b0;
   logic       tx_data_ready = 1'b0;
   logic       level;
   logic       event_pulse;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       busy;
   logic       overrun;

   int         n_checks     = 0;
   int         n_passed     = 0;
   logic [7:0] byte_q[$];
   bit         offered[128];
   int         pulse_cnt    = 0;
   int         valid_cycles = 0;
   logic       prev_hold    = 1'b0;
   logic       prev_pulse   = 1'b0;
   logic [7:0] prev_data    = 8'h00;
   bit         rand_ready   = 1'b0;
   int         ready_pct    = 50;

   async_event_reporter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .async_in     (async_in),
      .level        (level),
      .event_pulse  (event_pulse),
      .tx_data      (tx_data),
      .tx_data_valid(tx_data_valid),
      .tx_data_ready(tx_data_ready),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Byte that should be offered for a given count and the level at that moment.
   function automatic logic [7:0] exp_byte(input int cnt, input logic lvl);
      logic [7:0] c;
      c = cnt[7:0];
`ifdef ASYNC_EVENT_LEVEL_MSB_EN
      return {lvl, c[6:0]};
`else
      return c;
`endif
   endfunction

   // Passive monitor: records transfers, offered values and pulses; checks the handshake.
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         prev_hold  = 1'b0;
         prev_pulse = 1'b0;
      end else begin
         if (prev_hold) begin
            check_val("valid_held", tx_data_valid, 1);
            check_val("data_stable", tx_data, prev_data);
         end
         if (prev_pulse) begin
            check_val("pulse_one_cycle", event_pulse, 0);
         end
         if (tx_data_valid) begin
            valid_cycles++;
            offered[tx_data[6:0]] = 1'b1;
            check_val("busy_with_valid", busy, 1);
            if (tx_data_ready) begin
               byte_q.push_back(tx_data);
               $display("tx byte 0x%02h at %0t", tx_data, $time);
            end
         end
         if (event_pulse) pulse_cnt++;
         prev_pulse = event_pulse;
         prev_hold  = tx_data_valid && !tx_data_ready;
         prev_data  = tx_data;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         if (rand_ready) tx_data_ready = ($urandom_range(0, 99) < ready_pct);
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_level"}, level, 0);
      check_val({tag, "_pulse"}, event_pulse, 0);
      check_val({tag, "_data"}, tx_data, 8'h00);
      check_val({tag, "_valid"}, tx_data_valid, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_overrun"}, overrun, 0);
   endtask

   task automatic apply_reset();
      sys_rst       = 1'b1;
      async_in      = 1'b0;
      tx_data_ready = 1'b0;
      rand_ready    = 1'b0;
      step(3);
      @(negedge sys_clk);
      check_reset_outputs("reset");
      step(1);
      sys_rst = 1'b0;
      byte_q.delete();
      for (int i = 0; i < 128; i++) offered[i] = 1'b0;
      pulse_cnt    = 0;
      valid_cycles = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic cur;
      logic level_m;
      int   events_m;
      int   d;
      bit   missing;

      // Glitch shorter than the debounce window.
      apply_reset();
      tx_data_ready = 1'b1;
      async_in = 1'b1;
      step(3);
      async_in = 1'b0;
      step(20);
      @(negedge sys_clk);
      check_val("glitch_pulses", pulse_cnt, 0);
      check_val("glitch_level", level, 0);
      check_val("glitch_valid_cycles", valid_cycles, 0);
      step(1);

      // Single rising edge with ready tied high.
      apply_reset();
      tx_data_ready = 1'b1;
      async_in = 1'b1;
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge sys_clk);
         if (event_pulse) lat = i;
         @(posedge sys_clk);
         #1;
      end
      check_val("event_latency_ok",
                (lat >= SYNC_STAGES + DEBOUNCE_CYCLES) && (lat <= SYNC_STAGES + DEBOUNCE_CYCLES + 1), 1);
      @(negedge sys_clk);
      check_val("rise_valid", tx_data_valid, 1);
      check_val("rise_data", tx_data, exp_byte(1, 1'b1));
      check_val("rise_level", level, 1);
      step(1);
      @(negedge sys_clk);
      check_val("rise_valid_done", tx_data_valid, 0);
      check_val("rise_busy_done", busy, 0);
      step(12);
      check_val("rise_pulse_count", pulse_cnt, 1);
      check_val("rise_byte_count", byte_q.size(), 1);

      // Ready held low across three edges, then released.
      apply_reset();
      async_in = 1'b1; step(10);
      async_in = 1'b0; step(10);
      async_in = 1'b1; step(10);
      @(negedge sys_clk);
      check_val("stall_valid", tx_data_valid, 1);
      check_val("stall_data", tx_data, exp_byte(1, 1'b1));
      check_val("stall_overrun", overrun, 1);
      check_val("stall_busy", busy, 1);
      step(1);
      tx_data_ready = 1'b1;
      @(negedge sys_clk);
      check_val("release_first_data", tx_data, exp_byte(1, 1'b1));
      step(1);
      @(negedge sys_clk);
      check_val("gap_valid_low", tx_data_valid, 0);
      check_val("gap_busy", busy, 1);
      step(1);
      @(negedge sys_clk);
      check_val("second_valid", tx_data_valid, 1);
      check_val("second_data", tx_data, exp_byte(3, 1'b1));
      step(1);
      @(negedge sys_clk);
      check_val("drain_valid", tx_data_valid, 0);
      check_val("drain_busy", busy, 0);
      check_val("drain_byte_count", byte_q.size(), 2);
      step(1);

      // 256 well-spaced edges: counts wrap to zero, no overrun.
      apply_reset();
      tx_data_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         async_in = ~async_in;
         step(20);
      end
      step(10);
      @(negedge sys_clk);
      check_val("wrap_byte_count", byte_q.size(), 256);
      for (int i = 0; i < byte_q.size() && i < 256; i++) begin
         check_val("wrap_byte", byte_q[i], exp_byte(i + 1, ((i + 1) % 2) == 1));
      end
      check_val("wrap_overrun", overrun, 0);
      check_val("wrap_level", level, 0);
      step(1);

      // Reset while sending with an event pending.
      apply_reset();
      async_in = 1'b1; step(10);
      async_in = 1'b0; step(10);
      @(negedge sys_clk);
      check_val("midrst_valid", tx_data_valid, 1);
      check_val("midrst_busy", busy, 1);
      step(1);
      sys_rst = 1'b1;
      step(1);
      @(negedge sys_clk);
      check_reset_outputs("midrst");
      check_val("midrst_no_byte", byte_q.size(), 0);
      step(1);
      sys_rst = 1'b0;
      byte_q.delete();
      tx_data_ready = 1'b1;
      async_in = 1'b1;
      step(15);
      @(negedge sys_clk);
      check_val("postrst_byte_count", byte_q.size(), 1);
      check_val("postrst_byte", (byte_q.size() > 0) ? byte_q[0] : 8'h00, exp_byte(1, 1'b1));
      step(1);

      // Rise then fall: level travels with the byte when the option is built in.
      apply_reset();
      tx_data_ready = 1'b1;
      async_in = 1'b1; step(12);
      async_in = 1'b0; step(12);
      @(negedge sys_clk);
      check_val("msb_byte_count", byte_q.size(), 2);
      check_val("msb_byte0", (byte_q.size() > 0) ? byte_q[0] : 8'h00, exp_byte(1, 1'b1));
      check_val("msb_byte1", (byte_q.size() > 1) ? byte_q[1] : 8'h00, exp_byte(2, 1'b0));
      step(1);

      // Randomized segments of random length with random ready.
      for (int round = 0; round < 2; round++) begin
         apply_reset();
         rand_ready = 1'b1;
         ready_pct  = (round == 0) ? 60 : 15;
         cur        = 1'b0;
         level_m    = 1'b0;
         events_m   = 0;
         for (int seg = 0; seg < 80; seg++) begin
            cur = ~cur;
            d   = $urandom_range(1, 12);
            async_in = cur;
            step(d);
            if (cur != level_m && d >= DEBOUNCE_CYCLES) begin
               level_m = cur;
               events_m++;
            end
         end
         // The final value is held long enough to settle either way.
         if (cur != level_m) begin
            level_m = cur;
            events_m++;
         end
         rand_ready    = 1'b0;
         tx_data_ready = 1'b1;
         step(30);
         @(negedge sys_clk);
         check_val("rand_level", level, level_m);
         check_val("rand_pulses", pulse_cnt, events_m);
         check_val("rand_busy_idle", busy, 0);
         if (events_m == 0) begin
            check_val("rand_no_bytes", byte_q.size(), 0);
         end else begin
            check_val("rand_last_byte", (byte_q.size() > 0) ? byte_q[byte_q.size() - 1] : 8'h00,
                      exp_byte(events_m, level_m));
         end
         for (int i = 1; i < byte_q.size(); i++) begin
            check_val("rand_increasing", byte_q[i][6:0] > byte_q[i-1][6:0], 1);
         end
         missing = 1'b0;
         for (int c = 1; c <= events_m && c < 128; c++) begin
            if (!offered[c]) missing = 1'b1;
         end
         check_val("rand_overrun", overrun, missing);
         step(1);
      end

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
